// File: rtl/vga_pkg.sv
// Shared definitions for the quadrant VGA driver: default 640x480 timing,
// quadrant indices and the write-handshake FSM encoding.
package vga_pkg;

  function automatic int unsigned span4(input int unsigned a, input int unsigned b,
                                        input int unsigned c, input int unsigned d);
    return a + b + c + d;
  endfunction

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;
  localparam bit          SYNC_POL_DEF = 1'b0;

  localparam int unsigned H_TOTAL_DEF = span4(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int unsigned V_TOTAL_DEF = span4(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

  // Quadrant index = {row_down, col_right}
  localparam logic [1:0] QUAD_LU = 2'd0;
  localparam logic [1:0] QUAD_RU = 2'd1;
  localparam logic [1:0] QUAD_LD = 2'd2;
  localparam logic [1:0] QUAD_RD = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACK    = 2'd1,
    COMMIT = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/vga_quad_driver_if.sv
// Quadrant colour write channel: address/data/valid from the configuration
// side, ready back from the driver.
interface vga_quad_driver_if #(
  parameter int unsigned C_ADDR_WIDTH = 2,
  parameter int unsigned C_DATA_WIDTH = 8
) ();
  logic [C_ADDR_WIDTH-1:0] C_Addr;
  logic [C_DATA_WIDTH-1:0] C_Data;
  logic                    C_Valid;
  logic                    C_Rdy;

  modport master (output C_Addr, output C_Data, output C_Valid, input C_Rdy);
  modport slave  (input C_Addr, input C_Data, input C_Valid, output C_Rdy);
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running VGA pixel/line counters with combinational sync, active-area
// and end-of-frame flags derived from the current counter values.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter int unsigned HW       = $clog2(span4(H_ACTIVE, H_FP, H_SYNC, H_BP)),
  parameter int unsigned VW       = $clog2(span4(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          in_active,
  output logic          hsync_on,
  output logic          vsync_on,
  output logic          eof,
  output logic          frame_origin
);
  localparam int unsigned H_TOTAL = span4(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = span4(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_ALST = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign in_active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hsync_on     = (h_cnt >= H_SS) && (h_cnt < H_SE);
  assign vsync_on     = (v_cnt >= V_SS) && (v_cnt < V_SE);
  // Last clock of the last visible line: the commit window opens right after it
  assign eof          = (h_cnt == H_LAST) && (v_cnt == V_ALST);
  assign frame_origin = (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: rtl/vga_quad_driver.sv
// Quadrant colour VGA driver: shadow/active colour banks committed once per frame,
// write handshake FSM and registered sync/pixel outputs (latency 1 from counters).
// Optional colour-bar test pattern when VGA_TEST_PATTERN_EN is defined (adds VGA_debug).
module vga_quad_driver
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE     = H_ACTIVE_DEF,
  parameter int unsigned H_FP         = H_FP_DEF,
  parameter int unsigned H_SYNC       = H_SYNC_DEF,
  parameter int unsigned H_BP         = H_BP_DEF,
  parameter int unsigned V_ACTIVE     = V_ACTIVE_DEF,
  parameter int unsigned V_FP         = V_FP_DEF,
  parameter int unsigned V_SYNC       = V_SYNC_DEF,
  parameter int unsigned V_BP         = V_BP_DEF,
  parameter bit          SYNC_POL     = SYNC_POL_DEF,
  parameter int unsigned C_ADDR_WIDTH = 2,
  parameter int unsigned C_DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  vga_quad_driver_if.slave        cfg,
  input  logic                    Vertical_Split,
  input  logic                    Horizontal_Split,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                    VGA_debug,
`endif
  output logic                    HSync,
  output logic                    VSync,
  output logic [C_DATA_WIDTH-1:0] Pixel_Data,
  output logic                    Display_En,
  output logic                    Frame_Start
);
  localparam int unsigned H_TOTAL = span4(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = span4(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int          NQ      = 1 << C_ADDR_WIDTH;

  localparam logic [HW-1:0] H_HALF = HW'(H_ACTIVE / 2);
  localparam logic [VW-1:0] V_HALF = VW'(V_ACTIVE / 2);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          in_active;
  logic          hsync_on;
  logic          vsync_on;
  logic          eof;
  logic          frame_origin;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .HW       (HW),
    .VW       (VW)
  ) u_timing (
    .clk          (clk),
    .rst_n        (rst_n),
    .h_cnt        (h_cnt),
    .v_cnt        (v_cnt),
    .in_active    (in_active),
    .hsync_on     (hsync_on),
    .vsync_on     (vsync_on),
    .eof          (eof),
    .frame_origin (frame_origin)
  );

  logic [C_DATA_WIDTH-1:0] shadow_bank [NQ];
  logic [C_DATA_WIDTH-1:0] live_bank   [NQ];

  fsm_state_t state, state_nx;
  logic       rdy;
  logic       rdy_nx;
  logic       dirty;
  logic       eof_q;
  logic       accept;
  logic       do_commit;

  assign accept    = cfg.C_Valid && rdy;
  assign cfg.C_Rdy = rdy;

  // eof_q lets a write accepted on the end-of-frame cycle still reach the commit
  always_comb begin
    state_nx  = state;
    do_commit = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept)            state_nx = ACK;
        else if (eof && dirty) state_nx = COMMIT;
      end
      ACK: begin
        if ((eof || eof_q) && dirty) state_nx = COMMIT;
        else                         state_nx = IDLE;
      end
      COMMIT: begin
        do_commit = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    rdy_nx = (state_nx == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      rdy   <= 1'b0;
      dirty <= 1'b0;
      eof_q <= 1'b0;
      for (int i = 0; i < NQ; i++) begin
        shadow_bank[i] <= '0;
        live_bank[i]   <= '0;
      end
    end else begin
      state <= state_nx;
      rdy   <= rdy_nx;
      eof_q <= eof;
      if (accept) begin
        shadow_bank[cfg.C_Addr] <= cfg.C_Data;
        dirty                   <= 1'b1;
      end
      if (do_commit) begin
        live_bank <= shadow_bank;
        dirty     <= 1'b0;
      end
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [HW+2:0] H_ACT_W = (HW+3)'(H_ACTIVE);

  logic [HW+2:0]           bar_idx;
  logic [C_DATA_WIDTH-1:0] bar_colour;

  always_comb begin
    bar_idx    = {h_cnt, 3'b000} / H_ACT_W;
    bar_colour = C_DATA_WIDTH'(32'(bar_idx) * 32'h24);
  end
`endif

  logic                    col_right;
  logic                    row_down;
  logic [1:0]              quad;
  logic [C_DATA_WIDTH-1:0] pix_p0;

  always_comb begin
    col_right = Vertical_Split && (h_cnt >= H_HALF);
    row_down  = Horizontal_Split && (v_cnt >= V_HALF);
    quad      = {row_down, col_right};
    pix_p0    = '0;
    if (in_active) begin
      unique case (quad)
        QUAD_LU: pix_p0 = live_bank[QUAD_LU];
        QUAD_RU: pix_p0 = live_bank[QUAD_RU];
        QUAD_LD: pix_p0 = live_bank[QUAD_LD];
        QUAD_RD: pix_p0 = live_bank[QUAD_RD];
        default: pix_p0 = '0;
      endcase
`ifdef VGA_TEST_PATTERN_EN
      if (VGA_debug) pix_p0 = bar_colour;
`endif
    end
  end

  // Output register stage: everything below reflects the previous cycle's counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      HSync       <= ~SYNC_POL;
      VSync       <= ~SYNC_POL;
      Pixel_Data  <= '0;
      Display_En  <= 1'b0;
      Frame_Start <= 1'b0;
    end else begin
      HSync       <= hsync_on ? SYNC_POL : ~SYNC_POL;
      VSync       <= vsync_on ? SYNC_POL : ~SYNC_POL;
      Pixel_Data  <= pix_p0;
      Display_En  <= in_active;
      Frame_Start <= frame_origin && in_active;
    end
  end

endmodule
